// File: rtl/cache_control_nway.sv
// rtl/cache_control_nway.sv - N-way cache controller FSM with hit/miss performance counters
module cache_control_nway #(
    parameter int WAYS  = 2,
    parameter int CNT_W = 32,
    localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    input  logic             pmem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic [WAYS-1:0]  hit_vec,
    input  logic [WAYS-1:0]  dirty_vec,
    input  logic [WAYW-1:0]  lru_way,
    output logic             lru_load,
    output logic [WAYW-1:0]  lru_in,
    output logic [WAYS-1:0]  tag_load,
    output logic [WAYS-1:0]  valid_load,
    output logic [WAYS-1:0]  dirty_load,
    output logic             dirty_in,
    output logic [WAYW-1:0]  way_sel,
    output logic [1:0]       writing,
    output logic             pmem_addr_sel,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    typedef enum logic [1:0] {
        CHECK_HIT = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [WAYW-1:0] victim;
    logic            refill;
    logic            request;
    logic            hit_any;
    logic [WAYW-1:0] hit_way;
    logic            miss_evt;

    assign request = mem_read | mem_write;
    assign hit_any = |hit_vec;

    // Descending scan so the lowest matching way wins.
    always_comb begin
        hit_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_way = WAYW'(i);
            end
        end
    end

    // Gated by rst_n so every output sits at its idle value throughout reset.
    always_comb begin
        state_next    = state;
        miss_evt      = 1'b0;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        lru_load      = 1'b0;
        lru_in        = '0;
        tag_load      = '0;
        valid_load    = '0;
        dirty_load    = '0;
        dirty_in      = 1'b0;
        way_sel       = victim;
        writing       = 2'b11;
        pmem_addr_sel = 1'b0;
        if (rst_n) begin
            case (state)
                CHECK_HIT: begin
                    if (request && hit_any) begin
                        mem_resp = 1'b1;
                        way_sel  = hit_way;
                        lru_load = 1'b1;
                        lru_in   = hit_way;
                        if (mem_write) begin
                            dirty_load[hit_way] = 1'b1;
                            dirty_in            = 1'b1;
                            writing             = 2'b01;
                        end
                    end else if (request) begin
                        miss_evt   = 1'b1;
                        state_next = dirty_vec[lru_way] ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                    if (pmem_resp) begin
                        state_next = FILL;
                    end
                end
                FILL: begin
                    pmem_read = 1'b1;
                    writing   = 2'b00;
                    if (pmem_resp) begin
                        tag_load[victim]   = 1'b1;
                        valid_load[victim] = 1'b1;
                        dirty_load[victim] = 1'b1;
                        state_next         = CHECK_HIT;
                    end
                end
                default: state_next = CHECK_HIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= CHECK_HIT;
            victim <= '0;
            refill <= 1'b0;
        end else begin
            state <= state_next;
            if (miss_evt) begin
                victim <= lru_way;
                refill <= 1'b1;
            end else if (mem_resp) begin
                refill <= 1'b0;
            end
        end
    end

    // The response that completes a refill is not counted as a hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (cnt_clr) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (mem_resp && !refill && hit_count != {CNT_W{1'b1}}) begin
                hit_count <= hit_count + 1'b1;
            end
            if (miss_evt && miss_count != {CNT_W{1'b1}}) begin
                miss_count <= miss_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cache_control_nway.sv
// tb/tb_cache_control_nway.sv - directed and randomized bench for cache_control_nway
module tb_cache_control_nway;

    localparam int WAYS  = 4;
    localparam int WAYW  = 2;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             mem_read, mem_write, mem_resp;
    logic             pmem_resp, pmem_read, pmem_write;
    logic [WAYS-1:0]  hit_vec, dirty_vec;
    logic [WAYW-1:0]  lru_way;
    logic             lru_load;
    logic [WAYW-1:0]  lru_in;
    logic [WAYS-1:0]  tag_load, valid_load, dirty_load;
    logic             dirty_in;
    logic [WAYW-1:0]  way_sel;
    logic [1:0]       writing;
    logic             pmem_addr_sel;
    logic             cnt_clr;
    logic [CNT_W-1:0] hit_count, miss_count;

    cache_control_nway #(.WAYS(WAYS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .pmem_resp(pmem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .hit_vec(hit_vec), .dirty_vec(dirty_vec), .lru_way(lru_way),
        .lru_load(lru_load), .lru_in(lru_in),
        .tag_load(tag_load), .valid_load(valid_load), .dirty_load(dirty_load),
        .dirty_in(dirty_in), .way_sel(way_sel), .writing(writing),
        .pmem_addr_sel(pmem_addr_sel), .cnt_clr(cnt_clr),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int m_hit      = 0;
    int m_miss     = 0;
    bit m_refill   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [WAYS-1:0] v);
        for (int i = 0; i < WAYS; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic check_cnt(input string tag);
        check({tag, ".hit_count"}, 32'(hit_count), m_hit);
        check({tag, ".miss_count"}, 32'(miss_count), m_miss);
    endtask

    task automatic idle_inputs();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pmem_resp = 1'b0;
        cnt_clr   = 1'b0;
        hit_vec   = '0;
    endtask

    task automatic do_hit(input string tag, input bit wr, input logic [WAYS-1:0] hv, input bit clr);
        int w;
        w = lowest(hv);
        @(negedge clk);
        mem_write = wr;
        mem_read  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        hit_vec   = hv;
        cnt_clr   = clr;
        dirty_vec = WAYS'($urandom);
        lru_way   = WAYW'($urandom);
        #1;
        check({tag, ".mem_resp"}, 32'(mem_resp), 1);
        check({tag, ".way_sel"}, 32'(way_sel), w);
        check({tag, ".lru_load"}, 32'(lru_load), 1);
        check({tag, ".lru_in"}, 32'(lru_in), w);
        check({tag, ".dirty_load"}, 32'(dirty_load), wr ? (1 << w) : 0);
        check({tag, ".dirty_in"}, 32'(dirty_in), wr);
        check({tag, ".writing"}, 32'(writing), wr ? 1 : 3);
        check({tag, ".pmem_rw"}, {30'd0, pmem_read, pmem_write}, 0);
        @(posedge clk);
        if (clr) begin
            m_hit  = 0;
            m_miss = 0;
        end else if (!m_refill && m_hit < CMAX) begin
            m_hit++;
        end
        m_refill = 0;
        @(negedge clk);
        idle_inputs();
        #1;
        check_cnt(tag);
    endtask

    task automatic do_miss(input string tag, input bit wr, input int lru, input bit dirty,
                           input int wbn, input int filln, input bit drop);
        logic [WAYS-1:0] dv;
        dv = WAYS'($urandom);
        dv[lru] = dirty;
        @(negedge clk);
        mem_write = wr;
        mem_read  = !wr;
        hit_vec   = '0;
        lru_way   = WAYW'(lru);
        dirty_vec = dv;
        #1;
        check({tag, ".req_resp"}, 32'(mem_resp), 0);
        check({tag, ".req_pmem"}, {30'd0, pmem_read, pmem_write}, 0);
        @(posedge clk);
        if (m_miss < CMAX) m_miss++;
        m_refill = 1;
        if (dirty) begin
            for (int i = 0; i < wbn; i++) begin
                @(negedge clk);
                pmem_resp = (i == wbn - 1);
                lru_way   = WAYW'($urandom);
                #1;
                check({tag, ".wb_pmem_write"}, 32'(pmem_write), 1);
                check({tag, ".wb_addr_sel"}, 32'(pmem_addr_sel), 1);
                check({tag, ".wb_pmem_read"}, 32'(pmem_read), 0);
                check({tag, ".wb_resp"}, 32'(mem_resp), 0);
                @(posedge clk);
            end
        end
        for (int i = 0; i < filln; i++) begin
            @(negedge clk);
            pmem_resp = (i == filln - 1);
            lru_way   = WAYW'($urandom);
            if (drop) begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
            #1;
            check({tag, ".fill_pmem_read"}, 32'(pmem_read), 1);
            check({tag, ".fill_pmem_write"}, 32'(pmem_write), 0);
            check({tag, ".fill_addr_sel"}, 32'(pmem_addr_sel), 0);
            check({tag, ".fill_writing"}, 32'(writing), 0);
            check({tag, ".fill_resp"}, 32'(mem_resp), 0);
            check({tag, ".fill_tag_load"}, 32'(tag_load), pmem_resp ? (1 << lru) : 0);
            check({tag, ".fill_valid_load"}, 32'(valid_load), pmem_resp ? (1 << lru) : 0);
            check({tag, ".fill_dirty_load"}, 32'(dirty_load), pmem_resp ? (1 << lru) : 0);
            if (pmem_resp) check({tag, ".fill_dirty_in"}, 32'(dirty_in), 0);
            @(posedge clk);
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        hit_vec   = WAYS'(1 << lru);
        #1;
        if (drop) begin
            check({tag, ".drop_resp"}, 32'(mem_resp), 0);
            check({tag, ".drop_pmem"}, {30'd0, pmem_read, pmem_write}, 0);
        end else begin
            check({tag, ".relook_resp"}, 32'(mem_resp), 1);
            check({tag, ".relook_way_sel"}, 32'(way_sel), lru);
            check({tag, ".relook_lru_in"}, 32'(lru_in), lru);
            check({tag, ".relook_dirty_load"}, 32'(dirty_load), wr ? (1 << lru) : 0);
            check({tag, ".relook_writing"}, 32'(writing), wr ? 1 : 3);
            @(posedge clk);
            m_refill = 0;
        end
        @(negedge clk);
        idle_inputs();
        #1;
        check_cnt(tag);
    endtask

    initial begin
        rst_n     = 1'b1;
        dirty_vec = '0;
        lru_way   = '0;
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        check("rst.mem_resp", 32'(mem_resp), 0);
        check("rst.writing", 32'(writing), 3);
        check("rst.way_sel", 32'(way_sel), 0);
        check("rst.pmem", {30'd0, pmem_read, pmem_write}, 0);
        check_cnt("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_hit("read_hit_way2", 1'b0, 4'b0100, 1'b0);
        do_hit("write_hit_way0", 1'b1, 4'b0001, 1'b0);
        do_hit("multi_hit_lowest", 1'b0, 4'b1010, 1'b0);
        do_miss("dirty_read_miss", 1'b0, 3, 1'b1, 3, 3, 1'b0);
        do_miss("clean_miss_drop", 1'b0, 1, 1'b0, 0, 2, 1'b1);
        do_miss("clean_write_miss", 1'b1, 2, 1'b0, 0, 1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            do_hit("sat_hits", 1'($urandom_range(0, 1)), WAYS'($urandom_range(1, 15)), 1'b0);
        end
        check("sat.hit_count", 32'(hit_count), CMAX);
        do_hit("clr_with_hit", 1'b0, 4'b1000, 1'b1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_miss("rand_miss", 1'($urandom_range(0, 1)), $urandom_range(0, WAYS - 1),
                        1'($urandom_range(0, 1)), $urandom_range(1, 4), $urandom_range(1, 4),
                        $urandom_range(0, 4) == 0);
            end else begin
                do_hit("rand_hit", 1'($urandom_range(0, 1)), WAYS'($urandom_range(1, 15)),
                       $urandom_range(0, 9) == 0);
            end
        end

        // Reset in the middle of a fill must drop pmem_read before the next clock edge.
        @(negedge clk);
        mem_read  = 1'b1;
        hit_vec   = '0;
        dirty_vec = '0;
        lru_way   = 2'd1;
        @(negedge clk);
        hit_vec = 4'b0001;
        #1;
        check("rstfill.pmem_read_before", 32'(pmem_read), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstfill.pmem_read", 32'(pmem_read), 0);
        check("rstfill.pmem_write", 32'(pmem_write), 0);
        check("rstfill.mem_resp", 32'(mem_resp), 0);
        check("rstfill.writing", 32'(writing), 3);
        m_hit    = 0;
        m_miss   = 0;
        m_refill = 0;
        check_cnt("rstfill");
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        do_hit("post_reset_hit", 1'b0, 4'b0010, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cache_control_nway.md
CACHE_CONTROL_NWAY -- requirements
Module: cache_control_nway

Interface
REQ-001 Parameter WAYS, default 2: associativity; SHALL be a power of two, 2..8; WAYW = clog2(WAYS).
REQ-002 Parameter CNT_W, default 32: width of each performance counter.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset; SHALL be asynchronous and active-low.
REQ-005 mem_read  in  1  CPU read request, held until mem_resp.
REQ-006 mem_write  in  1  CPU write request, held until mem_resp.
REQ-007 mem_resp  out  1  one-cycle completion to CPU.
REQ-008 pmem_resp  in  1  physical memory completion.
REQ-009 pmem_read  out  1  line fill request.
REQ-010 pmem_write  out  1  line writeback request.
REQ-011 hit_vec  in  WAYS  per-way (tag match AND valid) for the indexed set.
REQ-012 dirty_vec  in  WAYS  per-way dirty bits of the indexed set.
REQ-013 lru_way  in  WAYW  replacement candidate for the indexed set.
REQ-014 lru_load  out  1 and lru_in  out  WAYW: record way lru_in as most-recently-used.
REQ-015 tag_load, valid_load, dirty_load  out  WAYS each: per-way array write enables.
REQ-016 dirty_in  out  1  value written on dirty_load.
REQ-017 way_sel  out  WAYW  data-array way select.
REQ-018 writing  out  2  data-array source: 00 fill from pmem, 01 CPU write, 11 none.
REQ-019 pmem_addr_sel  out  1  0 = CPU address, 1 = victim tag address.
REQ-020 cnt_clr  in  1; hit_count, miss_count  out  CNT_W each.

Function
REQ-021 States SHALL be CHECK_HIT, WRITEBACK, FILL; outputs default to 0, writing=11, way_sel=victim register.
REQ-022 A request is mem_read OR mem_write; both high SHALL be treated as a write.
REQ-023 CHECK_HIT, request, any hit_vec bit set: hit_way = lowest set index; same cycle mem_resp=1, way_sel=hit_way, lru_load=1, lru_in=hit_way; stay in CHECK_HIT.
REQ-024 Write hit additionally: dirty_load[hit_way]=1, dirty_in=1, writing=01.
REQ-025 CHECK_HIT, request, hit_vec=0: victim register SHALL latch lru_way; next state WRITEBACK if dirty_vec[lru_way], else FILL; mem_resp stays 0.
REQ-026 WRITEBACK: pmem_write=1, pmem_addr_sel=1; on pmem_resp go to FILL, else stay.
REQ-027 FILL: pmem_read=1, pmem_addr_sel=0, writing=00; on pmem_resp assert tag_load, valid_load, dirty_load of victim with dirty_in=0, go to CHECK_HIT.
REQ-028 After FILL, the re-lookup in CHECK_HIT SHALL hit and respond per REQ-023/024.
REQ-029 Latency: hit 0 wait cycles; clean miss = 1 + fill cycles + 1; dirty miss adds writeback cycles.
REQ-030 Request deasserted during WRITEBACK/FILL SHALL NOT abort; the sequence completes, then idles in CHECK_HIT.
REQ-031 miss_count SHALL increment once per miss on the REQ-025 transition.
REQ-032 A refill flag SHALL set on miss and clear on mem_resp; hit_count SHALL increment on mem_resp only when the flag is clear.
REQ-033 Counters SHALL saturate at all-ones; cnt_clr synchronously zeroes both and overrides same-cycle increments.

Reset
REQ-034 rst_n low SHALL immediately force state CHECK_HIT, victim 0, refill flag 0, counters 0, all outputs to REQ-021 defaults.
REQ-035 Reset asserted mid-WRITEBACK or mid-FILL SHALL drop pmem_write/pmem_read without waiting for clk or pmem_resp.

Verification
REQ-036 WAYS=4, read, hit_vec=0100 -> same-cycle mem_resp=1, way_sel=2, lru_in=2, hit_count=1.
REQ-037 Write, hit_vec=0001 -> dirty_load=0001, dirty_in=1, writing=01, mem_resp=1.
REQ-038 Read miss, lru_way=3, dirty_vec=1000, pmem_resp after 3 cycles each phase -> WRITEBACK 3 cycles, FILL 3 cycles, tag_load=1000, then mem_resp; miss_count=1, hit_count=0.
REQ-039 Clean miss with request dropped in FILL -> fill completes, returns to CHECK_HIT, no mem_resp.
REQ-040 CNT_W=4, 20 hits -> hit_count=15; cnt_clr with simultaneous hit -> 0.
REQ-041 rst_n low during FILL -> pmem_read=0 before next clk edge, state CHECK_HIT, counters 0.
